gps_gen_seq: RTL and testbench

GPS_GEN_SEQ -- requirements
Module: gps_gen_seq

---
 rtl/gps_gen_seq.sv | 122 ++++++++++++
 tb/tb_gps_gen_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_gen_seq.sv
// GPS C/A sequencer: aligns code phase, then produces chip, epoch and
// navigation-bit strobes and rotates the message word out MSB first.
module gps_gen_seq #(
    parameter int CLK_PER_CHIP    = 16,
    parameter int CHIPS_PER_EPOCH = 1023,
    parameter int EPOCHS_PER_BIT  = 20
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        start_in,
    input  logic        stop_in,
    input  logic        code_phase_done_in,
    input  logic        msg_load_in,
    input  logic [31:0] msg_word_in,
    output logic        ca_phase_start_out,
    output logic        ena_out,
    output logic        msg_out,
    output logic        epoch_out,
    output logic        bit_out,
    output logic        busy_out,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_RUN   = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam int DIV_W   = (CLK_PER_CHIP > 1)    ? $clog2(CLK_PER_CHIP)    : 1;
    localparam int CHIP_W  = (CHIPS_PER_EPOCH > 1) ? $clog2(CHIPS_PER_EPOCH) : 1;
    localparam int EPOCH_W = (EPOCHS_PER_BIT > 1)  ? $clog2(EPOCHS_PER_BIT)  : 1;

    localparam logic [DIV_W-1:0]   DIV_MAX   = DIV_W'(CLK_PER_CHIP - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
    localparam logic [CHIP_W-1:0]  CHIP_MAX  = CHIP_W'(CHIPS_PER_EPOCH - 1);
    localparam logic [CHIP_W-1:0]  CHIP_ONE  = CHIP_W'(1);
    localparam logic [EPOCH_W-1:0] EPOCH_MAX = EPOCH_W'(EPOCHS_PER_BIT - 1);
    localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CHIP_W-1:0]   chip_q, chip_d;
    logic [EPOCH_W-1:0]  epoch_q, epoch_d;
    logic [31:0]         shreg_q, shreg_d;

    logic counting_w;
    logic ena_w;
    logic epoch_w;
    logic bit_w;

    // Strobes are decoded purely from registered state, so no input reaches an output.
    assign counting_w = (state_q == S_RUN) || (state_q == S_STOP);
    assign ena_w      = counting_w && (div_q == DIV_MAX);
    assign epoch_w    = ena_w && (chip_q == CHIP_MAX);
    assign bit_w      = epoch_w && (epoch_q == EPOCH_MAX);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        chip_d  = chip_q;
        epoch_d = epoch_q;
        shreg_d = shreg_q;

        case (state_q)
            S_IDLE: begin
                if (start_in && !stop_in) state_d = S_ALIGN;
                if (msg_load_in) shreg_d = msg_word_in;
            end
            S_ALIGN: begin
                if (stop_in) begin
                    state_d = S_IDLE;
                end else if (code_phase_done_in) begin
                    state_d = S_RUN;
                    div_d   = '0;
                    chip_d  = '0;
                    epoch_d = '0;
                end
            end
            S_RUN: begin
                if (stop_in) state_d = S_STOP;
            end
            S_STOP: begin
                if (epoch_w) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (counting_w) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + DIV_ONE;
            if (ena_w) chip_d = (chip_q == CHIP_MAX) ? '0 : chip_q + CHIP_ONE;
            if (epoch_w) epoch_d = (epoch_q == EPOCH_MAX) ? '0 : epoch_q + EPOCH_ONE;
            if (bit_w) shreg_d = {shreg_q[30:0], shreg_q[31]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            chip_q  <= '0;
            epoch_q <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            chip_q  <= chip_d;
            epoch_q <= epoch_d;
            shreg_q <= shreg_d;
        end
    end

    assign ca_phase_start_out = (state_q == S_ALIGN);
    assign ena_out            = ena_w;
    assign epoch_out          = epoch_w;
    assign bit_out            = bit_w;
    assign msg_out            = shreg_q[31];
    assign busy_out           = (state_q != S_IDLE);
    assign state_out          = state_q;

endmodule

// File: tb/tb_gps_gen_seq.sv
// Directed bench for gps_gen_seq with short chip/epoch/bit periods
// (2 clocks per chip, 4 chips per epoch, 2 epochs per bit).
module tb_gps_gen_seq;

    logic        clk_in = 1'b0;
    logic        rst_in_n = 1'b0;
    logic        start_in = 1'b0;
    logic        stop_in = 1'b0;
    logic        code_phase_done_in = 1'b0;
    logic        msg_load_in = 1'b0;
    logic [31:0] msg_word_in = 32'h0;
    logic        ca_phase_start_out;
    logic        ena_out;
    logic        msg_out;
    logic        epoch_out;
    logic        bit_out;
    logic        busy_out;
    logic [1:0]  state_out;

    int n_vec = 0;
    int n_err = 0;

    // A5 = 1010_0101, shifted out MSB first, one bit per 16 clocks
    logic [7:0] exp_seq = 8'b1010_0101;

    gps_gen_seq #(
        .CLK_PER_CHIP(2),
        .CHIPS_PER_EPOCH(4),
        .EPOCHS_PER_BIT(2)
    ) dut (
        .clk_in(clk_in),
        .rst_in_n(rst_in_n),
        .start_in(start_in),
        .stop_in(stop_in),
        .code_phase_done_in(code_phase_done_in),
        .msg_load_in(msg_load_in),
        .msg_word_in(msg_word_in),
        .ca_phase_start_out(ca_phase_start_out),
        .ena_out(ena_out),
        .msg_out(msg_out),
        .epoch_out(epoch_out),
        .bit_out(bit_out),
        .busy_out(busy_out),
        .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        start_in = 1'b0;
        stop_in = 1'b0;
        code_phase_done_in = 1'b0;
        msg_load_in = 1'b0;
        msg_word_in = 32'h0;
        rst_in_n = 1'b0;
        step();
        step();
        rst_in_n = 1'b1;
    endtask

    task automatic load_and_run(input logic [31:0] word);
        msg_word_in = word;
        msg_load_in = 1'b1;
        step();
        msg_load_in = 1'b0;
        start_in = 1'b1;
        code_phase_done_in = 1'b1;
        step();
        start_in = 1'b0;
        step();
    endtask

    task automatic test_reset();
        start_in = 1'b0;
        stop_in = 1'b0;
        rst_in_n = 1'b0;
        step();
        n_vec++;
        if ({ca_phase_start_out, ena_out, msg_out, epoch_out, bit_out, busy_out, state_out} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs got %b exp 00000000",
                     {ca_phase_start_out, ena_out, msg_out, epoch_out, bit_out, busy_out, state_out});
        end
        rst_in_n = 1'b1;
    endtask

    task automatic test_run();
        logic exp_msg;
        apply_reset();
        msg_word_in = 32'hA500_0000;
        msg_load_in = 1'b1;
        step();
        msg_load_in = 1'b0;
        n_vec++;
        if (msg_out !== 1'b1) begin
            n_err++;
            $display("FAIL load_msg got %b exp 1", msg_out);
        end
        start_in = 1'b1;
        code_phase_done_in = 1'b1;
        step();
        start_in = 1'b0;
        n_vec++;
        if (state_out !== 2'd1 || ca_phase_start_out !== 1'b1 || busy_out !== 1'b1) begin
            n_err++;
            $display("FAIL run_align state=%0d ca=%b busy=%b exp 1 1 1",
                     state_out, ca_phase_start_out, busy_out);
        end
        step();
        for (int k = 0; k < 128; k++) begin
            exp_msg = exp_seq[7 - k / 16];
            n_vec++;
            if (state_out !== 2'd2 || ca_phase_start_out !== 1'b0) begin
                n_err++;
                $display("FAIL run_state k=%0d got %0d/%b exp 2/0", k, state_out, ca_phase_start_out);
            end
            n_vec++;
            if (ena_out !== (k % 2 == 1)) begin
                n_err++;
                $display("FAIL run_ena k=%0d got %b exp %b", k, ena_out, (k % 2 == 1));
            end
            n_vec++;
            if (epoch_out !== (k % 8 == 7)) begin
                n_err++;
                $display("FAIL run_epoch k=%0d got %b exp %b", k, epoch_out, (k % 8 == 7));
            end
            n_vec++;
            if (bit_out !== (k % 16 == 15)) begin
                n_err++;
                $display("FAIL run_bit k=%0d got %b exp %b", k, bit_out, (k % 16 == 15));
            end
            n_vec++;
            if (msg_out !== exp_msg) begin
                n_err++;
                $display("FAIL run_msg k=%0d got %b exp %b", k, msg_out, exp_msg);
            end
            step();
        end
    endtask

    task automatic test_align_hold();
        apply_reset();
        start_in = 1'b1;
        code_phase_done_in = 1'b0;
        step();
        start_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (state_out !== 2'd1 || ca_phase_start_out !== 1'b1 || ena_out !== 1'b0) begin
                n_err++;
                $display("FAIL align_hold i=%0d state=%0d ca=%b ena=%b exp 1 1 0",
                         i, state_out, ca_phase_start_out, ena_out);
            end
            if (i < 9) step();
        end
        code_phase_done_in = 1'b1;
        step();
        n_vec++;
        if (state_out !== 2'd2 || ca_phase_start_out !== 1'b0 || ena_out !== 1'b0) begin
            n_err++;
            $display("FAIL align_to_run state=%0d ca=%b ena=%b exp 2 0 0",
                     state_out, ca_phase_start_out, ena_out);
        end
        step();
        n_vec++;
        if (ena_out !== 1'b1) begin
            n_err++;
            $display("FAIL align_first_ena got %b exp 1", ena_out);
        end
    endtask

    task automatic test_stop();
        apply_reset();
        load_and_run(32'h0);
        step();
        step();
        stop_in = 1'b1;
        step();
        stop_in = 1'b0;
        for (int k = 3; k <= 7; k++) begin
            n_vec++;
            if (state_out !== 2'd3 || busy_out !== 1'b1) begin
                n_err++;
                $display("FAIL stop_state k=%0d got %0d/%b exp 3/1", k, state_out, busy_out);
            end
            n_vec++;
            if (ena_out !== (k % 2 == 1) || epoch_out !== (k == 7) || bit_out !== 1'b0) begin
                n_err++;
                $display("FAIL stop_strobes k=%0d ena=%b epoch=%b bit=%b exp %b %b 0",
                         k, ena_out, epoch_out, bit_out, (k % 2 == 1), (k == 7));
            end
            if (k == 4) stop_in = 1'b1;
            step();
            stop_in = 1'b0;
        end
        for (int k = 8; k <= 10; k++) begin
            n_vec++;
            if (state_out !== 2'd0 || busy_out !== 1'b0 || ena_out !== 1'b0 || epoch_out !== 1'b0) begin
                n_err++;
                $display("FAIL stop_idle k=%0d state=%0d busy=%b ena=%b epoch=%b exp 0 0 0 0",
                         k, state_out, busy_out, ena_out, epoch_out);
            end
            step();
        end
    endtask

    task automatic test_start_stop_idle();
        apply_reset();
        start_in = 1'b1;
        stop_in = 1'b1;
        step();
        start_in = 1'b0;
        stop_in = 1'b0;
        n_vec++;
        if (state_out !== 2'd0 || busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL start_stop_idle got %0d/%b exp 0/0", state_out, busy_out);
        end
        start_in = 1'b1;
        code_phase_done_in = 1'b0;
        step();
        start_in = 1'b0;
        stop_in = 1'b1;
        code_phase_done_in = 1'b1;
        step();
        stop_in = 1'b0;
        code_phase_done_in = 1'b0;
        n_vec++;
        if (state_out !== 2'd0 || ca_phase_start_out !== 1'b0) begin
            n_err++;
            $display("FAIL align_stop_priority got %0d/%b exp 0/0", state_out, ca_phase_start_out);
        end
    endtask

    task automatic test_load_in_run();
        logic exp_msg;
        apply_reset();
        load_and_run(32'hA500_0000);
        for (int k = 0; k < 64; k++) begin
            exp_msg = exp_seq[7 - k / 16];
            msg_load_in = (k == 3);
            msg_word_in = (k == 3) ? 32'h5A5A_5A5A : 32'h0;
            n_vec++;
            if (msg_out !== exp_msg) begin
                n_err++;
                $display("FAIL load_in_run_msg k=%0d got %b exp %b", k, msg_out, exp_msg);
            end
            step();
        end
        msg_load_in = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        load_and_run(32'hA500_0000);
        for (int k = 0; k < 5; k++) step();
        rst_in_n = 1'b0;
        #1;
        n_vec++;
        if ({ca_phase_start_out, ena_out, msg_out, epoch_out, bit_out, busy_out, state_out} !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset got %b exp 00000000",
                     {ca_phase_start_out, ena_out, msg_out, epoch_out, bit_out, busy_out, state_out});
        end
        step();
        n_vec++;
        if ({ena_out, busy_out, state_out} !== 4'h0) begin
            n_err++;
            $display("FAIL reset_held got %b exp 0000", {ena_out, busy_out, state_out});
        end
        start_in = 1'b1;
        code_phase_done_in = 1'b1;
        rst_in_n = 1'b1;
        step();
        start_in = 1'b0;
        n_vec++;
        if (state_out !== 2'd1) begin
            n_err++;
            $display("FAIL first_start got %0d exp 1", state_out);
        end
        step();
        for (int k = 0; k <= 8; k++) begin
            n_vec++;
            if (state_out !== 2'd2 || ena_out !== (k % 2 == 1) || epoch_out !== (k == 7) || msg_out !== 1'b0) begin
                n_err++;
                $display("FAIL restart k=%0d state=%0d ena=%b epoch=%b msg=%b exp 2 %b %b 0",
                         k, state_out, ena_out, epoch_out, msg_out, (k % 2 == 1), (k == 7));
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_align_hold();
        test_stop();
        test_start_stop_idle();
        test_load_in_run();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
